vram_arbiter: RTL and testbench
===============================

// Module: vram_arbiter
// PURPOSE
//   Shares one VRAM memory instance (1 registered read port, 1 write port) between
//   the display fetch unit and the CPU bus. Display reads have priority with a
//   bounded-starvation guard for CPU reads. CPU writes are buffered in a small
//   FIFO and drained to the write port. CPU read-after-write ordering is preserved.
// PARAMETERS
//   ADDRESS_WIDTH    10  VRAM address width, matches the memory instance
//   DATA_WIDTH       8   VRAM data width
//   FIFO_DEPTH_LOG2  2   log2 of CPU write FIFO depth (default 4 entries)
//   MAX_WAIT         15  contested cycles before CPU read overrides display; 0 = guard off
// PORTS
//   clk              in   1    system clock, all logic on posedge
//   reset_n          in   1    asynchronous, active-low reset
//   disp_req         in   1    display read request, addr held until granted
//   disp_addr        in   AW   display read address
//   disp_gnt         out  1    display request accepted this cycle (combinational)
//   disp_rvalid      out  1    disp_rdata valid (registered)
//   disp_rdata       out  DW   display read data
//   cpu_rd_req       in   1    CPU read request, addr held until granted
//   cpu_rd_addr      in   AW   CPU read address
//   cpu_rd_gnt       out  1    CPU read accepted this cycle (combinational)
//   cpu_rvalid       out  1    cpu_rdata valid (registered)
//   cpu_rdata        out  DW   CPU read data
//   cpu_wr_req       in   1    CPU write request
//   cpu_wr_addr      in   AW   CPU write address
//   cpu_wr_data      in   DW   CPU write data
//   cpu_wr_ready     out  1    FIFO can accept; write taken when req && ready
//   wr_hold          in   1    display asks to freeze write drain (anti-tearing)
//   wr_fifo_empty    out  1    no CPU writes pending
//   mem_read_addr    out  AW   to memory read_addr
//   mem_read_enable  out  1    to memory read_enable
//   mem_read_data    in   DW   from memory read_data (valid 1 cycle after enable)
//   mem_write_addr   out  AW   to memory write_addr
//   mem_write_enable out  1    to memory write_enable
//   mem_write_data   out  DW   to memory write_data
// BEHAVIOUR
//   - Reset: FIFO empty, starve counter 0, disp_rvalid=cpu_rvalid=0, mem_*_enable=0,
//     cpu_wr_ready=1, wr_fifo_empty=1. Reset mid-op drops in-flight rvalid and FIFO contents.
//   - Read port, per cycle: cpu_eligible = cpu_rd_req && wr_fifo_empty.
//     disp_req && !(cpu_eligible && starve_cnt==MAX_WAIT && MAX_WAIT!=0) -> disp_gnt;
//     else cpu_eligible -> cpu_rd_gnt. At most one grant per cycle.
//   - Granted cycle T: mem_read_enable=1, mem_read_addr=winner addr. Cycle T+1:
//     winner's rvalid=1 (registered), rdata = mem_read_data. Throughput 1 read/cycle.
//     No grant -> mem_read_enable=0, read_addr don't-care.
//   - Starve counter: +1 (saturating at MAX_WAIT) on cycle with cpu_eligible and
//     disp_gnt; cleared on cpu_rd_gnt or !cpu_rd_req. Width clog2(MAX_WAIT+1).
//   - Write FIFO: push on cpu_wr_req && cpu_wr_ready; cpu_wr_ready = !full (no
//     push-when-full even if popping). Pop when !empty && !wr_hold: mem_write_enable=1,
//     addr/data = FIFO head, driven from registered state. Pop+push same cycle allowed.
//     Pointers wrap modulo depth; full/empty via extra pointer MSB.
//   - Ordering: CPU read granted only when FIFO empty, so every accepted prior write
//     is in memory before the read. A write accepted in the same cycle as cpu_rd_gnt
//     is ordered after that read (read returns old data).
//   - Display reads never wait on the FIFO; display sees writes as they drain.
//   - wr_hold held indefinitely: FIFO fills, cpu_wr_ready=0, CPU reads blocked.
// TESTING
//   - Reset then disp read addr 0x005 (init 0xA5) -> disp_gnt same cycle, next cycle
//     disp_rvalid=1, disp_rdata=0xA5; all resets values checked mid-op reset too.
//   - CPU write 0x010<=0x3C then immediate CPU read 0x010 -> read waits for drain,
//     cpu_rdata=0x3C.
//   - disp_req held high, cpu_rd_req high, MAX_WAIT=15 -> cpu_rd_gnt on 16th
//     contested cycle, disp_gnt=0 that cycle, counter cleared after.
//   - wr_hold=1, 5 CPU writes -> 4 accepted, cpu_wr_ready=0 on 5th; release ->
//     4 consecutive mem_write_enable cycles in order, wr_fifo_empty=1 after.
//   - Same-cycle cpu_wr (0x020<=0x77) and cpu_rd_gnt to 0x020 (old 0x11) -> rdata 0x11.
//   - Back-to-back disp reads 0x000..0x0FF -> one rvalid per cycle, data matches model.

Source files
------------

// File: rtl/vram_arbiter_if.sv
// Bundle of the display, CPU and memory-side signals around the VRAM arbiter.
// The arbiter takes the slave view; clients and the memory model take the master view.
interface vram_arbiter_if #(
    parameter int ADDRESS_WIDTH = 10,
    parameter int DATA_WIDTH    = 8
);
    logic                     disp_req;
    logic [ADDRESS_WIDTH-1:0] disp_addr;
    logic                     disp_gnt;
    logic                     disp_rvalid;
    logic [DATA_WIDTH-1:0]    disp_rdata;

    logic                     cpu_rd_req;
    logic [ADDRESS_WIDTH-1:0] cpu_rd_addr;
    logic                     cpu_rd_gnt;
    logic                     cpu_rvalid;
    logic [DATA_WIDTH-1:0]    cpu_rdata;

    logic                     cpu_wr_req;
    logic [ADDRESS_WIDTH-1:0] cpu_wr_addr;
    logic [DATA_WIDTH-1:0]    cpu_wr_data;
    logic                     cpu_wr_ready;
    logic                     wr_hold;
    logic                     wr_fifo_empty;

    logic [ADDRESS_WIDTH-1:0] mem_read_addr;
    logic                     mem_read_enable;
    logic [DATA_WIDTH-1:0]    mem_read_data;
    logic [ADDRESS_WIDTH-1:0] mem_write_addr;
    logic                     mem_write_enable;
    logic [DATA_WIDTH-1:0]    mem_write_data;

    modport slave (
        input  disp_req, disp_addr,
        output disp_gnt, disp_rvalid, disp_rdata,
        input  cpu_rd_req, cpu_rd_addr,
        output cpu_rd_gnt, cpu_rvalid, cpu_rdata,
        input  cpu_wr_req, cpu_wr_addr, cpu_wr_data, wr_hold,
        output cpu_wr_ready, wr_fifo_empty,
        output mem_read_addr, mem_read_enable,
        input  mem_read_data,
        output mem_write_addr, mem_write_enable, mem_write_data
    );

    modport master (
        output disp_req, disp_addr,
        input  disp_gnt, disp_rvalid, disp_rdata,
        output cpu_rd_req, cpu_rd_addr,
        input  cpu_rd_gnt, cpu_rvalid, cpu_rdata,
        output cpu_wr_req, cpu_wr_addr, cpu_wr_data, wr_hold,
        input  cpu_wr_ready, wr_fifo_empty,
        input  mem_read_addr, mem_read_enable,
        output mem_read_data,
        input  mem_write_addr, mem_write_enable, mem_write_data
    );
endinterface

// File: rtl/vram_arbiter.sv
// Shares one VRAM (registered read port + write port) between display fetch and CPU:
// display-priority reads with a CPU starvation guard, and a buffered CPU write FIFO.
module vram_arbiter #(
    parameter int ADDRESS_WIDTH   = 10,
    parameter int DATA_WIDTH      = 8,
    parameter int FIFO_DEPTH_LOG2 = 2,
    parameter int MAX_WAIT        = 15
) (
    input  logic          clk,
    input  logic          reset_n,
    vram_arbiter_if.slave bus
);
    localparam int FIFO_DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int STARVE_W   = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [STARVE_W-1:0]      STARVE_MAX = STARVE_W'(MAX_WAIT);
    localparam logic [STARVE_W-1:0]      STARVE_ONE = STARVE_W'(1);
    localparam logic [FIFO_DEPTH_LOG2:0] PTR_ONE    = (FIFO_DEPTH_LOG2 + 1)'(1);

    // Write FIFO state
    logic [FIFO_DEPTH_LOG2:0]   wr_ptr_q, wr_ptr_d;
    logic [FIFO_DEPTH_LOG2:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDRESS_WIDTH-1:0]   fifo_addr_q [FIFO_DEPTH];
    logic [ADDRESS_WIDTH-1:0]   fifo_addr_d [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]      fifo_data_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]      fifo_data_d [FIFO_DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] wr_idx;
    logic [FIFO_DEPTH_LOG2-1:0] rd_idx;
    logic                       fifo_empty;
    logic                       fifo_full;
    logic                       push;
    logic                       pop;

    // Read arbitration state
    logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;
    logic                disp_rvalid_q, disp_rvalid_d;
    logic                cpu_rvalid_q, cpu_rvalid_d;
    logic                cpu_eligible;
    logic                starve_override;
    logic                disp_gnt;
    logic                cpu_gnt;

    assign wr_idx = wr_ptr_q[FIFO_DEPTH_LOG2-1:0];
    assign rd_idx = rd_ptr_q[FIFO_DEPTH_LOG2-1:0];

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[FIFO_DEPTH_LOG2] != rd_ptr_q[FIFO_DEPTH_LOG2]) &&
                        (wr_idx == rd_idx);

    // Readiness is purely !full so it never depends on the same-cycle pop.
    assign push = bus.cpu_wr_req && !fifo_full;
    assign pop  = !fifo_empty && !bus.wr_hold;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        fifo_addr_d = fifo_addr_q;
        fifo_data_d = fifo_data_q;
        if (push) begin
            fifo_addr_d[wr_idx] = bus.cpu_wr_addr;
            fifo_data_d[wr_idx] = bus.cpu_wr_data;
            wr_ptr_d            = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Entry storage carries no reset; validity is defined by the pointers alone.
    always_ff @(posedge clk) begin
        fifo_addr_q <= fifo_addr_d;
        fifo_data_q <= fifo_data_d;
    end

    assign bus.cpu_wr_ready     = !fifo_full;
    assign bus.wr_fifo_empty    = fifo_empty;
    assign bus.mem_write_enable = pop;
    assign bus.mem_write_addr   = fifo_addr_q[rd_idx];
    assign bus.mem_write_data   = fifo_data_q[rd_idx];

    // A CPU read is only eligible once every accepted write has reached memory,
    // so a write accepted alongside the read grant lands after the read.
    assign cpu_eligible    = bus.cpu_rd_req && fifo_empty;
    assign starve_override = (MAX_WAIT != 0) && cpu_eligible && (starve_cnt_q == STARVE_MAX);
    assign disp_gnt        = bus.disp_req && !starve_override;
    assign cpu_gnt         = cpu_eligible && !disp_gnt;

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (cpu_gnt || !bus.cpu_rd_req) begin
            starve_cnt_d = '0;
        end else if (cpu_eligible && disp_gnt && (starve_cnt_q != STARVE_MAX)) begin
            starve_cnt_d = starve_cnt_q + STARVE_ONE;
        end
    end

    // Stage boundary: grant cycle T -> read data cycle T+1
    always_comb begin
        disp_rvalid_d = disp_gnt;
        cpu_rvalid_d  = cpu_gnt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt_q  <= '0;
            disp_rvalid_q <= 1'b0;
            cpu_rvalid_q  <= 1'b0;
        end else begin
            starve_cnt_q  <= starve_cnt_d;
            disp_rvalid_q <= disp_rvalid_d;
            cpu_rvalid_q  <= cpu_rvalid_d;
        end
    end

    assign bus.disp_gnt        = disp_gnt;
    assign bus.cpu_rd_gnt      = cpu_gnt;
    assign bus.mem_read_enable = disp_gnt || cpu_gnt;
    assign bus.mem_read_addr   = disp_gnt ? bus.disp_addr : bus.cpu_rd_addr;

    // The memory's registered output belongs to whichever requester was granted last cycle.
    assign bus.disp_rvalid = disp_rvalid_q;
    assign bus.disp_rdata  = bus.mem_read_data;
    assign bus.cpu_rvalid  = cpu_rvalid_q;
    assign bus.cpu_rdata   = bus.mem_read_data;

    a_one_grant: assert property (@(posedge clk) disable iff (!reset_n)
        !(disp_gnt && cpu_gnt));
    a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
        !(push && fifo_full));
    a_cpu_read_ordered: assert property (@(posedge clk) disable iff (!reset_n)
        cpu_gnt |-> fifo_empty);
endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: behavioural VRAM, a read-data scoreboard and one task per scenario.
module tb_vram_arbiter;
    localparam int AW = 10;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    vram_arbiter_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus();

    vram_arbiter #(
        .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH_LOG2(2), .MAX_WAIT(15)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus.slave)
    );

    logic [DW-1:0] vmem      [1<<AW];
    logic [DW-1:0] model_mem [1<<AW];
    logic [DW-1:0] disp_exp_q [$];
    logic [DW-1:0] cpu_exp_q  [$];
    logic [DW-1:0] exp_v;
    int checks = 0;
    int errors = 0;
    int disp_rvalid_seen = 0;

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            vmem[i]      = 8'hA0 ^ DW'(i);
            model_mem[i] = 8'hA0 ^ DW'(i);
        end
        vmem[10'h020]      = 8'h11;
        model_mem[10'h020] = 8'h11;
    end

    // Memory with a registered read port; read-during-write returns old data
    always @(posedge clk) begin
        if (bus.mem_read_enable) bus.mem_read_data <= vmem[bus.mem_read_addr];
        if (bus.mem_write_enable) vmem[bus.mem_write_addr] <= bus.mem_write_data;
    end

    // Scoreboard: expected data captured at grant, compared when rvalid returns
    always @(negedge clk) begin
        if (reset_n) begin
            if (bus.disp_rvalid) begin
                disp_rvalid_seen++;
                checks++;
                if (disp_exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL disp_rvalid_unexpected: got rdata %h with no read outstanding", bus.disp_rdata);
                end else begin
                    exp_v = disp_exp_q.pop_front();
                    if (bus.disp_rdata !== exp_v) begin
                        errors++;
                        $display("FAIL disp_rdata_sb: got %h want %h", bus.disp_rdata, exp_v);
                    end
                end
            end
            if (bus.cpu_rvalid) begin
                checks++;
                if (cpu_exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL cpu_rvalid_unexpected: got rdata %h with no read outstanding", bus.cpu_rdata);
                end else begin
                    exp_v = cpu_exp_q.pop_front();
                    if (bus.cpu_rdata !== exp_v) begin
                        errors++;
                        $display("FAIL cpu_rdata_sb: got %h want %h", bus.cpu_rdata, exp_v);
                    end
                end
            end
            if (bus.disp_gnt)   disp_exp_q.push_back(model_mem[bus.disp_addr]);
            if (bus.cpu_rd_gnt) cpu_exp_q.push_back(model_mem[bus.cpu_rd_addr]);
            if (bus.cpu_wr_req && bus.cpu_wr_ready) model_mem[bus.cpu_wr_addr] = bus.cpu_wr_data;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus.disp_req = 1'b0; bus.disp_addr = '0;
        bus.cpu_rd_req = 1'b0; bus.cpu_rd_addr = '0;
        bus.cpu_wr_req = 1'b0; bus.cpu_wr_addr = '0; bus.cpu_wr_data = '0;
        bus.wr_hold = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (bus.disp_rvalid !== 1'b0) begin errors++; $display("FAIL reset_disp_rvalid: got %b want 0", bus.disp_rvalid); end
        checks++; if (bus.cpu_rvalid !== 1'b0) begin errors++; $display("FAIL reset_cpu_rvalid: got %b want 0", bus.cpu_rvalid); end
        checks++; if (bus.mem_read_enable !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b want 0", bus.mem_read_enable); end
        checks++; if (bus.mem_write_enable !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b want 0", bus.mem_write_enable); end
        checks++; if (bus.cpu_wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready: got %b want 1", bus.cpu_wr_ready); end
        checks++; if (bus.wr_fifo_empty !== 1'b1) begin errors++; $display("FAIL reset_fifo_empty: got %b want 1", bus.wr_fifo_empty); end
        checks++; if (dut.starve_cnt_q !== '0) begin errors++; $display("FAIL reset_starve: got %0d want 0", dut.starve_cnt_q); end
        #2 reset_n = 1'b1;
    endtask

    task automatic test_disp_read();
        step();
        bus.disp_req = 1'b1; bus.disp_addr = 10'h005;
        @(negedge clk);
        checks++; if (bus.disp_gnt !== 1'b1) begin errors++; $display("FAIL disp_gnt: got %b want 1", bus.disp_gnt); end
        checks++; if (bus.mem_read_enable !== 1'b1) begin errors++; $display("FAIL disp_rd_en: got %b want 1", bus.mem_read_enable); end
        checks++; if (bus.mem_read_addr !== 10'h005) begin errors++; $display("FAIL disp_rd_addr: got %h want 005", bus.mem_read_addr); end
        checks++; if (bus.disp_rvalid !== 1'b0) begin errors++; $display("FAIL disp_rvalid_early: got %b want 0", bus.disp_rvalid); end
        step();
        bus.disp_req = 1'b0;
        @(negedge clk);
        checks++; if (bus.disp_rvalid !== 1'b1) begin errors++; $display("FAIL disp_rvalid: got %b want 1", bus.disp_rvalid); end
        checks++; if (bus.disp_rdata !== 8'hA5) begin errors++; $display("FAIL disp_rdata: got %h want a5", bus.disp_rdata); end
        checks++; if (bus.cpu_rvalid !== 1'b0) begin errors++; $display("FAIL disp_cpu_rvalid: got %b want 0", bus.cpu_rvalid); end
        checks++; if (bus.mem_read_enable !== 1'b0) begin errors++; $display("FAIL idle_rd_en: got %b want 0", bus.mem_read_enable); end
    endtask

    task automatic test_read_after_write();
        int cyc;
        logic granted;
        step();
        bus.cpu_wr_req = 1'b1; bus.cpu_wr_addr = 10'h010; bus.cpu_wr_data = 8'h3C;
        @(negedge clk);
        checks++; if (bus.cpu_wr_ready !== 1'b1) begin errors++; $display("FAIL raw_wr_ready: got %b want 1", bus.cpu_wr_ready); end
        step();
        bus.cpu_wr_req = 1'b0;
        bus.cpu_rd_req = 1'b1; bus.cpu_rd_addr = 10'h010;
        @(negedge clk);
        checks++; if (bus.cpu_rd_gnt !== 1'b0) begin errors++; $display("FAIL raw_early_gnt: got %b want 0", bus.cpu_rd_gnt); end
        checks++; if (bus.mem_write_enable !== 1'b1) begin errors++; $display("FAIL raw_drain_en: got %b want 1", bus.mem_write_enable); end
        checks++; if ({bus.mem_write_addr, bus.mem_write_data} !== {10'h010, 8'h3C}) begin errors++; $display("FAIL raw_drain: got %h/%h want 010/3c", bus.mem_write_addr, bus.mem_write_data); end
        cyc = 0; granted = 1'b0;
        while (!granted && cyc < 8) begin
            step();
            @(negedge clk);
            cyc++;
            if (bus.cpu_rd_gnt === 1'b1) granted = 1'b1;
        end
        checks++; if (granted !== 1'b1 || cyc != 1) begin errors++; $display("FAIL raw_gnt_timing: got granted=%b after %0d cycles want 1 after 1", granted, cyc); end
        step();
        bus.cpu_rd_req = 1'b0;
        @(negedge clk);
        checks++; if (bus.cpu_rvalid !== 1'b1) begin errors++; $display("FAIL raw_rvalid: got %b want 1", bus.cpu_rvalid); end
        checks++; if (bus.cpu_rdata !== 8'h3C) begin errors++; $display("FAIL raw_rdata: got %h want 3c", bus.cpu_rdata); end
    endtask

    task automatic test_starvation();
        int n;
        logic granted;
        step();
        bus.disp_req = 1'b1; bus.disp_addr = 10'h040;
        bus.cpu_rd_req = 1'b1; bus.cpu_rd_addr = 10'h041;
        n = 0; granted = 1'b0;
        while (!granted && n < 40) begin
            @(negedge clk);
            n++;
            if (bus.cpu_rd_gnt === 1'b1) begin
                granted = 1'b1;
                checks++; if (bus.disp_gnt !== 1'b0) begin errors++; $display("FAIL starve_disp_gnt: got %b want 0", bus.disp_gnt); end
            end else begin
                step();
            end
        end
        checks++; if (granted !== 1'b1 || n != 16) begin errors++; $display("FAIL starve_gnt_cycle: got granted=%b at cycle %0d want 1 at 16", granted, n); end
        step();
        @(negedge clk);
        checks++; if (bus.disp_gnt !== 1'b1 || bus.cpu_rd_gnt !== 1'b0) begin errors++; $display("FAIL starve_after: got disp=%b cpu=%b want 1/0", bus.disp_gnt, bus.cpu_rd_gnt); end
        checks++; if (dut.starve_cnt_q !== '0) begin errors++; $display("FAIL starve_cleared: got %0d want 0", dut.starve_cnt_q); end
        step();
        bus.disp_req = 1'b0; bus.cpu_rd_req = 1'b0;
    endtask

    task automatic test_wr_hold();
        step();
        bus.wr_hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.cpu_wr_req = 1'b1; bus.cpu_wr_addr = AW'(10'h100 + i); bus.cpu_wr_data = DW'(8'h50 + i);
            @(negedge clk);
            checks++; if (bus.cpu_wr_ready !== (i < 4)) begin errors++; $display("FAIL hold_ready_%0d: got %b want %b", i, bus.cpu_wr_ready, (i < 4)); end
            checks++; if (bus.mem_write_enable !== 1'b0) begin errors++; $display("FAIL hold_wr_en_%0d: got %b want 0", i, bus.mem_write_enable); end
            step();
        end
        bus.cpu_wr_req = 1'b0;
        bus.cpu_rd_req = 1'b1; bus.cpu_rd_addr = 10'h100;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (bus.cpu_rd_gnt !== 1'b0 || bus.wr_fifo_empty !== 1'b0) begin errors++; $display("FAIL hold_blocked_%0d: got gnt=%b empty=%b want 0/0", i, bus.cpu_rd_gnt, bus.wr_fifo_empty); end
            step();
        end
        bus.wr_hold = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (bus.mem_write_enable !== 1'b1 || bus.mem_write_addr !== AW'(10'h100 + k) || bus.mem_write_data !== DW'(8'h50 + k) || bus.cpu_rd_gnt !== 1'b0) begin
                errors++;
                $display("FAIL drain_%0d: got en=%b %h/%h gnt=%b want 1 %h/%h 0", k, bus.mem_write_enable, bus.mem_write_addr, bus.mem_write_data, bus.cpu_rd_gnt, AW'(10'h100 + k), DW'(8'h50 + k));
            end
            step();
        end
        @(negedge clk);
        checks++; if (bus.wr_fifo_empty !== 1'b1 || bus.mem_write_enable !== 1'b0) begin errors++; $display("FAIL drain_done: got empty=%b en=%b want 1/0", bus.wr_fifo_empty, bus.mem_write_enable); end
        checks++; if (bus.cpu_rd_gnt !== 1'b1) begin errors++; $display("FAIL drain_rd_gnt: got %b want 1", bus.cpu_rd_gnt); end
        step();
        bus.cpu_rd_req = 1'b0;
    endtask

    task automatic test_same_cycle();
        step();
        bus.cpu_rd_req = 1'b1; bus.cpu_rd_addr = 10'h020;
        bus.cpu_wr_req = 1'b1; bus.cpu_wr_addr = 10'h020; bus.cpu_wr_data = 8'h77;
        @(negedge clk);
        checks++; if (bus.cpu_rd_gnt !== 1'b1 || bus.cpu_wr_ready !== 1'b1) begin errors++; $display("FAIL same_gnt: got gnt=%b ready=%b want 1/1", bus.cpu_rd_gnt, bus.cpu_wr_ready); end
        step();
        bus.cpu_rd_req = 1'b0; bus.cpu_wr_req = 1'b0;
        @(negedge clk);
        checks++; if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== 8'h11) begin errors++; $display("FAIL same_old_data: got v=%b %h want 1 11", bus.cpu_rvalid, bus.cpu_rdata); end
        checks++; if (bus.mem_write_enable !== 1'b1 || bus.mem_write_data !== 8'h77) begin errors++; $display("FAIL same_drain: got en=%b %h want 1 77", bus.mem_write_enable, bus.mem_write_data); end
        step();
        bus.cpu_rd_req = 1'b1; bus.cpu_rd_addr = 10'h020;
        @(negedge clk);
        checks++; if (bus.cpu_rd_gnt !== 1'b1) begin errors++; $display("FAIL same_reread_gnt: got %b want 1", bus.cpu_rd_gnt); end
        step();
        bus.cpu_rd_req = 1'b0;
        @(negedge clk);
        checks++; if (bus.cpu_rdata !== 8'h77) begin errors++; $display("FAIL same_new_data: got %h want 77", bus.cpu_rdata); end
    endtask

    task automatic test_back_to_back();
        int start;
        start = disp_rvalid_seen;
        for (int a = 0; a < 256; a++) begin
            step();
            bus.disp_req = 1'b1; bus.disp_addr = AW'(a);
            @(negedge clk);
            checks++; if (bus.disp_gnt !== 1'b1) begin errors++; $display("FAIL b2b_gnt_%0d: got %b want 1", a, bus.disp_gnt); end
            if (a > 0) begin
                checks++; if (bus.disp_rvalid !== 1'b1) begin errors++; $display("FAIL b2b_rvalid_%0d: got %b want 1", a, bus.disp_rvalid); end
            end
        end
        step();
        bus.disp_req = 1'b0;
        @(negedge clk);
        step();
        checks++; if (disp_rvalid_seen - start != 256) begin errors++; $display("FAIL b2b_count: got %0d want 256", disp_rvalid_seen - start); end
    endtask

    task automatic test_mid_reset();
        step();
        bus.wr_hold = 1'b1;
        bus.cpu_wr_req = 1'b1; bus.cpu_wr_addr = 10'h300; bus.cpu_wr_data = 8'h60;
        @(negedge clk);
        step();
        bus.cpu_wr_addr = 10'h301; bus.cpu_wr_data = 8'h61;
        @(negedge clk);
        step();
        bus.cpu_wr_req = 1'b0;
        bus.disp_req = 1'b1; bus.disp_addr = 10'h006;
        @(negedge clk);
        checks++; if (bus.disp_gnt !== 1'b1 || bus.wr_fifo_empty !== 1'b0) begin errors++; $display("FAIL mid_setup: got gnt=%b empty=%b want 1/0", bus.disp_gnt, bus.wr_fifo_empty); end
        #2;
        reset_n = 1'b0;
        bus.disp_req = 1'b0; bus.wr_hold = 1'b0;
        disp_exp_q.delete();
        cpu_exp_q.delete();
        @(negedge clk);
        checks++; if (bus.disp_rvalid !== 1'b0 || bus.cpu_rvalid !== 1'b0) begin errors++; $display("FAIL mid_rvalid: got disp=%b cpu=%b want 0/0", bus.disp_rvalid, bus.cpu_rvalid); end
        checks++; if (bus.mem_read_enable !== 1'b0 || bus.mem_write_enable !== 1'b0) begin errors++; $display("FAIL mid_enables: got rd=%b wr=%b want 0/0", bus.mem_read_enable, bus.mem_write_enable); end
        checks++; if (bus.cpu_wr_ready !== 1'b1 || bus.wr_fifo_empty !== 1'b1) begin errors++; $display("FAIL mid_fifo: got ready=%b empty=%b want 1/1", bus.cpu_wr_ready, bus.wr_fifo_empty); end
        checks++; if (dut.starve_cnt_q !== '0) begin errors++; $display("FAIL mid_starve: got %0d want 0", dut.starve_cnt_q); end
        #2 reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            @(negedge clk);
            checks++; if (bus.mem_write_enable !== 1'b0 || bus.wr_fifo_empty !== 1'b1 || bus.disp_rvalid !== 1'b0) begin errors++; $display("FAIL mid_after_%0d: got wr_en=%b empty=%b rvalid=%b want 0/1/0", i, bus.mem_write_enable, bus.wr_fifo_empty, bus.disp_rvalid); end
        end
    endtask

    initial begin
        test_reset();
        test_disp_read();
        test_read_after_write();
        test_starvation();
        test_wr_hold();
        test_same_cycle();
        test_back_to_back();
        test_mid_reset();
        repeat (3) step();
        checks++; if (disp_exp_q.size() != 0 || cpu_exp_q.size() != 0) begin errors++; $display("FAIL sb_drained: got %0d/%0d outstanding want 0/0", disp_exp_q.size(), cpu_exp_q.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
